// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared types and constants for the MIPS next-PC logic.
//   npc_state_t  - next-PC sequencer state (straight-line, delay slot, halted)
//   RESET_VECTOR - default fetch address while reset is asserted
//   HALT_ADDR    - transfer target that halts the core after its delay slot
//   PC_STEP      - byte distance between sequential instructions
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    SLOT = 2'd1,
    HALT = 2'd2
  } npc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/mips_cpu_npc_target.sv
// mips_cpu_npc_target: combinational target arithmetic for the next-PC block.
//   pc_curr        in  current PC
//   branch_taken   in  conditional branch taken
//   branch_offset  in  16-bit word offset
//   jump           in  J/JAL
//   jump_index     in  26-bit instr_index
//   jump_reg       in  JR/JALR
//   jump_reg_addr  in  rs value
//   seq            out pc_curr + 4 (wraps modulo 2^32)
//   tgt            out priority-selected transfer target
//   xfer           out any control transfer requested
module mips_cpu_npc_target
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc_curr,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_addr,
  output logic [31:0] seq,
  output logic [31:0] tgt,
  output logic        xfer
);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] br_disp;

  assign seq     = pc_curr + PC_STEP;
  // Word offset sign-extended to a byte displacement.
  assign br_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign br_tgt  = seq + br_disp;
  // Jump stays within the 256 MB region of the delay-slot instruction.
  assign j_tgt   = {seq[31:28], jump_index, 2'b00};
  assign xfer    = jump_reg | jump | branch_taken;

  always_comb begin
    tgt = br_tgt;
    if (jump_reg)  tgt = jump_reg_addr;
    else if (jump) tgt = j_tgt;
  end

endmodule

// File: rtl/mips_cpu_npc.sv
// mips_cpu_npc: next-PC generator with single-instruction branch delay slot,
// jump-to-HALT_ADDR halt detection and stall hold.
//   clk, rst       clock; asynchronous active-low reset
//   stall          memory wait, freezes state and holds PC
//   instr_valid    instruction at pc_curr executes this cycle
//   pc_curr        current PC
//   branch_taken/branch_offset, jump/jump_index, jump_reg/jump_reg_addr
//                  control-transfer requests (jump_reg > jump > branch)
//   npc_out        next PC to the PC register
//   delay_slot     pc_curr holds a delay-slot instruction
//   halted         core halted until reset
//   ctrl_err       one-cycle pulse: transfer attempted inside a delay slot
module mips_cpu_npc
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        instr_valid,
  input  logic [31:0] pc_curr,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_addr,
  output logic [31:0] npc_out,
  output logic        delay_slot,
  output logic        halted,
  output logic        ctrl_err
);

  npc_state_t  state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        ctrl_err_q, ctrl_err_d;
  logic [31:0] seq, tgt;
  logic        xfer;
  logic        accept;

  mips_cpu_npc_target u_target (
    .pc_curr       (pc_curr),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jump_reg_addr (jump_reg_addr),
    .seq           (seq),
    .tgt           (tgt),
    .xfer          (xfer)
  );

  assign accept = instr_valid & ~stall;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    // Recomputed every cycle so the error never outlives one cycle.
    ctrl_err_d = 1'b0;
    if (accept) begin
      unique case (state_q)
        SEQ: begin
          if (xfer) begin
            target_d = tgt;
            state_d  = SLOT;
          end
        end
        SLOT: begin
          // The slot instruction's own transfer request is dropped.
          ctrl_err_d = xfer;
          state_d    = (target_q == HALT_ADDR) ? HALT : SEQ;
        end
        default: state_d = HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SEQ;
      target_q   <= '0;
      ctrl_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      ctrl_err_q <= ctrl_err_d;
    end
  end

  always_comb begin
    npc_out = seq;
    if (!rst)                 npc_out = RESET_VECTOR;
    else if (state_q == HALT) npc_out = HALT_ADDR;
    else if (stall)           npc_out = pc_curr;
    else if (state_q == SLOT) npc_out = target_q;
  end

  assign delay_slot = (state_q == SLOT);
  assign halted     = (state_q == HALT);
  assign ctrl_err   = ctrl_err_q;

endmodule

// File: tb/tb_mips_cpu_npc.sv
// Directed-vector bench for mips_cpu_npc.
module tb_mips_cpu_npc;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        instr_valid;
  logic [31:0] pc_curr;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jump_reg_addr;
  logic [31:0] npc_out;
  logic        delay_slot;
  logic        halted;
  logic        ctrl_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_cpu_npc dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .pc_curr       (pc_curr),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jump_reg_addr (jump_reg_addr),
    .npc_out       (npc_out),
    .delay_slot    (delay_slot),
    .halted        (halted),
    .ctrl_err      (ctrl_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow #1 later.
  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    branch_offset = '0; jump_index = '0; jump_reg_addr = '0;
  endtask

  initial begin
    rst = 0; instr_valid = 0; pc_curr = 32'hBFC0_0000;
    idle();
    #1;
    chk("rst_npc", npc_out, 32'hBFC0_0000);
    chk("rst_ds", {31'd0, delay_slot}, 0);
    chk("rst_halt", {31'd0, halted}, 0);
    chk("rst_err", {31'd0, ctrl_err}, 0);
    edge_(); edge_();
    chk("rst_hold_npc", npc_out, 32'hBFC0_0000);

    // Reset release and straight-line fetch.
    rst = 1; instr_valid = 1; pc_curr = 32'hBFC0_0000;
    #1;
    chk("seq_npc", npc_out, 32'hBFC0_0004);
    chk("seq_ds", {31'd0, delay_slot}, 0);
    edge_();

    // Taken backward branch: target BFC00014 - 8.
    pc_curr = 32'hBFC0_0010; branch_taken = 1; branch_offset = 16'hFFFE;
    #1;
    chk("br_cycN_npc", npc_out, 32'hBFC0_0014);
    edge_();
    idle(); pc_curr = 32'hBFC0_0014;
    #1;
    chk("br_slot_ds", {31'd0, delay_slot}, 1);
    chk("br_slot_npc", npc_out, 32'hBFC0_000C);
    edge_();
    pc_curr = 32'hBFC0_000C;
    #1;
    chk("br_after_ds", {31'd0, delay_slot}, 0);
    chk("br_after_npc", npc_out, 32'hBFC0_0010);
    edge_();

    // Jump wins over a simultaneous branch.
    pc_curr = 32'hBFC0_0020; jump = 1; jump_index = 26'h000_0040;
    branch_taken = 1; branch_offset = 16'h0010;
    edge_();
    idle(); pc_curr = 32'hBFC0_0024;
    #1;
    chk("j_slot_npc", npc_out, 32'hB000_0100);
    chk("j_slot_ds", {31'd0, delay_slot}, 1);
    edge_();
    chk("j_no_err", {31'd0, ctrl_err}, 0);

    // JR followed by a 3-cycle stall in the slot.
    pc_curr = 32'hB000_0100; jump_reg = 1; jump_reg_addr = 32'h0040_0000;
    edge_();
    idle(); pc_curr = 32'hB000_0104; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_npc", npc_out, 32'hB000_0104);
      chk("stall_ds", {31'd0, delay_slot}, 1);
      edge_();
    end
    stall = 0;
    #1;
    chk("post_stall_npc", npc_out, 32'h0040_0000);
    edge_();

    // Branch inside the slot: error pulse, original target kept.
    pc_curr = 32'h0040_0000; branch_taken = 1; branch_offset = 16'h0004;
    edge_();
    pc_curr = 32'h0040_0004; branch_taken = 1; branch_offset = 16'h0100;
    #1;
    chk("err_slot_npc", npc_out, 32'h0040_0014);
    chk("err_pre", {31'd0, ctrl_err}, 0);
    edge_();
    idle(); pc_curr = 32'h0040_0014;
    chk("err_pulse", {31'd0, ctrl_err}, 1);
    #1;
    chk("err_ds", {31'd0, delay_slot}, 0);
    chk("err_seq_npc", npc_out, 32'h0040_0018);
    edge_();
    chk("err_clear", {31'd0, ctrl_err}, 0);

    // Sequential wrap to address 0 is not a halt.
    pc_curr = 32'hFFFF_FFFC;
    #1;
    chk("wrap_npc", npc_out, 32'h0000_0000);
    edge_();
    chk("wrap_no_halt", {31'd0, halted}, 0);
    chk("wrap_ds", {31'd0, delay_slot}, 0);

    // No valid instruction: branch request must not advance state.
    instr_valid = 0; pc_curr = 32'h0000_1000; branch_taken = 1; branch_offset = 16'h0040;
    #1;
    chk("inv_npc", npc_out, 32'h0000_1004);
    edge_();
    chk("inv_ds", {31'd0, delay_slot}, 0);

    // Reset in the middle of a slot discards the pending target.
    instr_valid = 1;
    edge_();
    chk("rmid_ds", {31'd0, delay_slot}, 1);
    idle(); rst = 0;
    #1;
    chk("rmid_ds_clr", {31'd0, delay_slot}, 0);
    edge_();
    rst = 1; pc_curr = 32'h0000_1044;
    #1;
    chk("rmid_npc", npc_out, 32'h0000_1048);
    edge_();

    // JR to HALT_ADDR: halt one edge after the slot.
    pc_curr = 32'h0000_1000; jump_reg = 1; jump_reg_addr = 32'h0;
    edge_();
    idle(); pc_curr = 32'h0000_1004;
    #1;
    chk("halt_slot_npc", npc_out, 32'h0);
    chk("halt_slot_h", {31'd0, halted}, 0);
    edge_();
    chk("halt_set", {31'd0, halted}, 1);
    for (int i = 0; i < 4; i++) begin
      stall = i[0]; jump = 1; jump_index = 26'h123_4567; pc_curr = 32'h8000_0000 + i;
      edge_();
      chk("halt_sticky", {31'd0, halted}, 1);
      chk("halt_npc", npc_out, 32'h0);
    end
    idle(); rst = 0;
    #1;
    chk("halt_rst_clr", {31'd0, halted}, 0);
    chk("halt_rst_npc", npc_out, 32'hBFC0_0000);
    edge_();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
